fetch_unit: RTL

- Front-end fetch stage that sits directly upstream of the controller/decoder.
- Owns the fetch PC and drives the synchronous instruction memory, which has 1-cycle read latency.
- Buffers fetched 9-bit instructions in a small prefetch FIFO and presents them to the controller over a valid/ready handshake.
- Handles jump redirects from the controller (flush plus refetch) and raises done once the end-of-program marker is reached and the FIFO has drained.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : front-end fetch stage with prefetch FIFO and redirects       |
// | Optional macro FETCH_STATS_EN adds fetch_count / flush_count outputs.     |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               imem_eof,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
`ifdef FETCH_STATS_EN
  output logic [15:0]        fetch_count,
  output logic [7:0]         flush_count,
`endif
  output logic               done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_addr_q, inflight_addr_d;
  logic               epoch_q, epoch_d;
  logic               req_epoch_q, req_epoch_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [INSTR_W-1:0] mem_instr_d [DEPTH];
  logic [PC_W-1:0]    mem_pc_q [DEPTH];
  logic [PC_W-1:0]    mem_pc_d [DEPTH];
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic               resp_ok;
  logic               push;
  logic               pop;
  logic               eof_hit;
  logic [CNT_W:0]     credit_used;

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    epoch_d         = epoch_q;
    req_epoch_d     = req_epoch_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    mem_instr_d     = mem_instr_q;
    mem_pc_d        = mem_pc_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    valid_d         = 1'b0;
    done_d          = 1'b0;

    // Credits: buffered entries plus the one possibly in flight never exceed DEPTH.
    credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    imem_req    = reset && (state_q == ST_RUN) && !redirect &&
                  (credit_used < (CNT_W+1)'(DEPTH));

    resp_ok = inflight_q && (req_epoch_q == epoch_q) && (state_q == ST_RUN) && !redirect;
    eof_hit = resp_ok && imem_eof;
    push    = resp_ok && !imem_eof;
    pop     = valid_q && instr_ready && !redirect;

    if (eof_hit) state_d = ST_HALT;

    if (imem_req) begin
      inflight_d      = 1'b1;
      inflight_addr_d = fetch_pc_q;
      req_epoch_d     = epoch_q;
      if (!eof_hit) fetch_pc_d = fetch_pc_q + PC_W'(1);
    end

    if (push) begin
      mem_instr_d[wr_ptr_q] = imem_instr;
      mem_pc_d[wr_ptr_q]    = inflight_addr_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fetch_pc_d = redirect_target;
      state_d    = ST_RUN;
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end

    // Head registers keep their last value once the FIFO runs empty.
    valid_d = (count_d != '0);
    if (valid_d) begin
      instr_d    = mem_instr_d[rd_ptr_d];
      instr_pc_d = mem_pc_d[rd_ptr_d];
    end

    done_d = !redirect && (state_q == ST_HALT) && (count_q == '0) && !inflight_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      fetch_pc_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      epoch_q         <= 1'b0;
      req_epoch_q     <= 1'b0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
      instr_q         <= '0;
      instr_pc_q      <= '0;
      valid_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      epoch_q         <= epoch_d;
      req_epoch_q     <= req_epoch_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      mem_instr_q     <= mem_instr_d;
      mem_pc_q        <= mem_pc_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      valid_q         <= valid_d;
      done_q          <= done_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q && !redirect;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [7:0]  flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (pop && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
    if (redirect && (flush_count_q != 8'hFF)) flush_count_d = flush_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire
